// File: rtl/amba_axi_pkg.sv
// Shared AXI constants, write-FSM state type and PCM path defaults.
package amba_axi_pkg;

  localparam int unsigned PCM_WORD_LENGTH      = 16;
  localparam int unsigned PCM_BUS_SIZE         = 4 * PCM_WORD_LENGTH;
  localparam int unsigned PCM_HALF_WINDOW_SIZE = 512;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILL,
    ADDR,
    DATA,
    RESP,
    DONE
  } axi_wr_state_t;

endpackage

// File: rtl/pcm_burst_fifo.sv
// Synchronous FIFO buffering PCM beats ahead of the AXI W channel.
// Depth must be a power of two so the pointers wrap naturally.
module pcm_burst_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/amba_axi_pcm_write.sv
// AXI write master: buffers PCM beats and writes one half-window frame
// as fixed-length INCR bursts, one burst in flight at a time.
module amba_axi_pcm_write
  import amba_axi_pkg::*;
#(
  parameter int unsigned WORD_LENGTH      = PCM_WORD_LENGTH,
  parameter int unsigned BUS_SIZE         = 4 * WORD_LENGTH,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned HALF_WINDOW_SIZE = PCM_HALF_WINDOW_SIZE,
  parameter int unsigned BURST_LEN        = 16,
  parameter int unsigned FIFO_DEPTH       = 2 * BURST_LEN
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  pcm_valid,
  output logic                  pcm_ready,
  input  logic [BUS_SIZE-1:0]   pcm_data,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [BUS_SIZE-1:0]   wdata,
  output logic [BUS_SIZE/8-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int unsigned FRAME_BEATS = HALF_WINDOW_SIZE / 4;
  localparam int unsigned NUM_BURSTS  = FRAME_BEATS / BURST_LEN;
  localparam int unsigned BURST_BYTES = BURST_LEN * (BUS_SIZE / 8);
  localparam int unsigned BEAT_W      = $clog2(BURST_LEN);
  localparam int unsigned BURST_W     = $clog2(NUM_BURSTS + 1);
  localparam int unsigned IN_W        = $clog2(FRAME_BEATS + 1);
  localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

  axi_wr_state_t         state_q;
  axi_wr_state_t         state_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic                  err_q;
  logic [BURST_W-1:0]    burst_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [IN_W-1:0]       in_cnt_q;

  logic [BUS_SIZE-1:0]   fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;

  logic start_acc;
  logic pcm_fire;
  logic w_fire;
  logic b_fire;

  assign start_acc = (state_q == IDLE) & start;
  assign pcm_fire  = pcm_valid & pcm_ready;
  assign w_fire    = wvalid & wready;
  assign b_fire    = bvalid & bready;

  assign awaddr  = addr_q;
  assign err     = err_q;
  assign awlen   = 8'(BURST_LEN - 1);
  assign awsize  = AXI_SIZE_8B;
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = '1;

  pcm_burst_fifo #(
    .WIDTH (BUS_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (pcm_fire),
    .wdata   (pcm_data),
    .pop     (w_fire & ~fifo_empty),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: AW only once a full burst is buffered.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:      if (start) state_nxt = WAIT_FILL;
      WAIT_FILL: if (fifo_count >= FIFO_CNT_W'(BURST_LEN)) state_nxt = ADDR;
      ADDR:      if (awready) state_nxt = DATA;
      DATA:      if (wready && wlast) state_nxt = RESP;
      RESP: begin
        if (bvalid) begin
          state_nxt = (burst_q == BURST_W'(NUM_BURSTS - 1)) ? DONE : WAIT_FILL;
        end
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register; no ready-to-valid paths.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    wdata     = '0;
    bready    = 1'b0;
    pcm_ready = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      ADDR: awvalid = 1'b1;
      DATA: begin
        wvalid = 1'b1;
        wdata  = fifo_rdata;
        wlast  = (beat_q == BEAT_W'(BURST_LEN - 1));
      end
      RESP: bready = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
    pcm_ready = busy & ~fifo_full & (in_cnt_q < IN_W'(FRAME_BEATS));
  end

  // Frame datapath: address, sticky error and beat/burst counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q   <= '0;
      err_q    <= 1'b0;
      burst_q  <= '0;
      beat_q   <= '0;
      in_cnt_q <= '0;
    end else if (start_acc) begin
      addr_q   <= base_addr & ~ADDR_W'(BURST_BYTES - 1);
      err_q    <= 1'b0;
      burst_q  <= '0;
      beat_q   <= '0;
      in_cnt_q <= '0;
    end else begin
      if (pcm_fire) in_cnt_q <= in_cnt_q + IN_W'(1);
      if (w_fire)   beat_q   <= beat_q + BEAT_W'(1);
      if (b_fire) begin
        err_q   <= err_q | (bresp != AXI_RESP_OKAY);
        burst_q <= burst_q + BURST_W'(1);
        addr_q  <= addr_q + ADDR_W'(BURST_BYTES);
      end
    end
  end

endmodule
